// File: rtl/mem_if_pkg.sv
// Shared types and constants for the cache external-memory port and its responder model.
package mem_if_pkg;

  localparam int MEM_WORD_W = 32;
  localparam int MEM_ADDR_W = 32;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10 of a left-shifting register
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    RESP_IDLE = 2'b00,
    RESP_BUSY = 2'b01,
    RESP_FULL = 2'b10
  } resp_state_e;

  typedef struct packed {
    logic                  valid;
    logic [MEM_WORD_W-1:0] data;
  } resp_beat_t;

  localparam resp_beat_t BEAT_IDLE = '{valid: 1'b0, data: 32'h0000_0000};

  function automatic logic [MEM_ADDR_W-1:0] word_index(input logic [MEM_ADDR_W-1:0] addr,
                                                       input int aw);
    logic [MEM_ADDR_W-1:0] mask;
    mask = (32'd1 << aw) - 32'd1;
    return (addr >> 2) & mask;
  endfunction

endpackage

// File: rtl/mem_resp_pipe.sv
// Fixed-depth valid/data delay line for read returns; i_flush drops everything in flight.
module mem_resp_pipe
  import mem_if_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic                  i_clk,
  input  logic                  i_flush,
  input  logic                  i_load,
  input  logic [MEM_WORD_W-1:0] i_data,
  output logic                  o_valid,
  output logic [MEM_WORD_W-1:0] o_data
);

  resp_beat_t pipe_r [LATENCY];

  // Shift register; empty stages carry zero data so the output is zero whenever it is not valid.
  always_ff @(posedge i_clk) begin
    if (i_flush) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_r[i] <= BEAT_IDLE;
      end
    end else begin
      pipe_r[0].valid <= i_load;
      pipe_r[0].data  <= i_load ? i_data : 32'h0000_0000;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end

  assign o_valid = pipe_r[LATENCY-1].valid;
  assign o_data  = pipe_r[LATENCY-1].data;

endmodule

// File: rtl/mem_responder.sv
// Word-granular backing-memory responder with fixed read latency and bounded outstanding reads.
// Define MEM_RESPONDER_RANDOM_STALL_EN to add LFSR-driven random ready stalls.
module mem_responder
  import mem_if_pkg::*;
#(
  parameter int AW      = 10,
  parameter int LATENCY = 4,
  parameter int MAX_OUT = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  output logic                  o_mem_ready,
  input  logic [MEM_ADDR_W-1:0] i_mem_addr,
  input  logic                  i_mem_ren,
  input  logic                  i_mem_wen,
  input  logic [MEM_WORD_W-1:0] i_mem_wdata,
  output logic [MEM_WORD_W-1:0] o_mem_rdata,
  output logic                  o_mem_valid
);

  localparam int             CW        = $clog2(MAX_OUT + 1);
  localparam int             DEPTH     = 1 << AW;
  localparam logic [CW-1:0]  MAX_OUT_C = CW'(MAX_OUT);

  logic [MEM_WORD_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]         word_s;
  logic [MEM_WORD_W-1:0] rd_word_s;
  logic                  acc_s;
  logic                  rd_acc_s;
  logic                  wr_acc_s;
  logic                  stall_s;
  logic [CW-1:0]         out_r;
  logic [CW-1:0]         out_next_s;
  resp_state_e           state_s;

  assign word_s   = AW'(word_index(i_mem_addr, AW));
  assign acc_s    = (i_mem_ren | i_mem_wen) & o_mem_ready;
  // A request with both strobes set is a write; no read is queued for it.
  assign wr_acc_s = acc_s & i_mem_wen;
  assign rd_acc_s = acc_s & i_mem_ren & ~i_mem_wen;

`ifdef MEM_RESPONDER_RANDOM_STALL_EN
  logic [15:0] lfsr_r;

  // Free-running stall generator, restarted from the seed on reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lfsr_r <= LFSR_SEED;
    end else begin
      lfsr_r <= {lfsr_r[14:0], ^(lfsr_r & LFSR_TAPS)};
    end
  end

  assign stall_s = (lfsr_r[1:0] == 2'b00);
`else
  assign stall_s = 1'b0;
`endif

  // Occupancy classification; ready depends only on this registered state.
  always_comb begin
    state_s = RESP_IDLE;
    if (out_r == {CW{1'b0}}) begin
      state_s = RESP_IDLE;
    end else if (out_r < MAX_OUT_C) begin
      state_s = RESP_BUSY;
    end else begin
      state_s = RESP_FULL;
    end
  end

  assign o_mem_ready = ~i_rst & (state_s != RESP_FULL) & ~stall_s;

  // Outstanding-read count: a return and a new accept in the same cycle cancel out.
  always_comb begin
    out_next_s = out_r;
    case ({rd_acc_s, o_mem_valid})
      2'b10:   out_next_s = out_r + CW'(1);
      2'b01:   out_next_s = out_r - CW'(1);
      default: out_next_s = out_r;
    endcase
  end

  // Outstanding counter register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_r <= {CW{1'b0}};
    end else begin
      out_r <= out_next_s;
    end
  end

  // Storage array; contents deliberately survive reset.
  always_ff @(posedge i_clk) begin
    if (wr_acc_s) begin
      mem_r[word_s] <= i_mem_wdata;
    end
  end

  assign rd_word_s = mem_r[word_s];

  mem_resp_pipe #(
    .LATENCY (LATENCY)
  ) u_pipe (
    .i_clk   (i_clk),
    .i_flush (i_rst),
    .i_load  (rd_acc_s),
    .i_data  (rd_word_s),
    .o_valid (o_mem_valid),
    .o_data  (o_mem_rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: driver pushes expected returns, monitor pops and compares.
module tb_mem_responder;

  localparam int AW      = 10;
  localparam int LATENCY = 4;
  localparam int MAX_OUT = 2;
  localparam int DEPTH   = 1 << AW;

  logic        i_clk;
  logic        i_rst;
  logic        o_mem_ready;
  logic [31:0] i_mem_addr;
  logic        i_mem_ren;
  logic        i_mem_wen;
  logic [31:0] i_mem_wdata;
  logic [31:0] o_mem_rdata;
  logic        o_mem_valid;

  mem_responder #(.AW(AW), .LATENCY(LATENCY), .MAX_OUT(MAX_OUT)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .o_mem_ready (o_mem_ready),
    .i_mem_addr  (i_mem_addr),
    .i_mem_ren   (i_mem_ren),
    .i_mem_wen   (i_mem_wen),
    .i_mem_wdata (i_mem_wdata),
    .o_mem_rdata (o_mem_rdata),
    .o_mem_valid (o_mem_valid)
  );

  typedef struct {
    logic [31:0] data;
    int          ret;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_mem [DEPTH];
  int          tests   = 0;
  int          fails   = 0;
  int          cyc     = 0;
  int          rdy_low = 0;
  int          rdy_obs = 0;

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: one sample per cycle, shortly after the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge i_clk);
      #1;
`ifdef MEM_RESPONDER_RANDOM_STALL_EN
      if (o_mem_ready) check_bit("ready_allowed", (!i_rst && sb_q.size() < MAX_OUT), 1'b1);
      if (!i_rst && sb_q.size() < MAX_OUT) begin
        rdy_obs++;
        if (!o_mem_ready) rdy_low++;
      end
`else
      check_bit("ready", o_mem_ready, (!i_rst && sb_q.size() < MAX_OUT));
`endif
      if (o_mem_valid) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_valid: valid=1 at cycle %0d, expected none in flight", cyc);
        end else begin
          e = sb_q.pop_front();
          check("rdata", o_mem_rdata, e.data);
          check_int("latency", cyc, e.ret);
        end
      end else begin
        check("rdata_idle", o_mem_rdata, 32'h0000_0000);
        if (sb_q.size() > 0 && sb_q[0].ret <= cyc) begin
          tests++;
          fails++;
          $display("FAIL missing_valid: valid=0 at cycle %0d, expected return due at %0d",
                   cyc, sb_q[0].ret);
          void'(sb_q.pop_front());
        end
      end
    end
  end

  // One cycle of stimulus; the reference model is updated only when the request is taken.
  task automatic drive(input logic ren, input logic wen, input logic [31:0] addr,
                       input logic [31:0] wdata, output bit acc);
    int   idx;
    exp_t e;
    @(negedge i_clk);
    i_mem_ren   = ren;
    i_mem_wen   = wen;
    i_mem_addr  = addr;
    i_mem_wdata = wdata;
    acc = o_mem_ready && (ren || wen);
    if (acc) begin
      idx = int'((addr >> 2) % DEPTH);
      if (wen) begin
        model_mem[idx] = wdata;
      end else begin
        e.data = model_mem[idx];
        e.ret  = cyc + LATENCY;
        sb_q.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    bit a;
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 32'h0, 32'h0, a);
  endtask

  // Hold a request like a cache initiator until it is taken.
  task automatic req(input logic ren, input logic wen, input logic [31:0] addr,
                     input logic [31:0] wdata, output int acc_cyc);
    bit a;
    acc_cyc = -1;
    for (int t = 0; t < 100; t++) begin
      drive(ren, wen, addr, wdata, a);
      if (a) begin
        acc_cyc = cyc;
        return;
      end
    end
    tests++;
    fails++;
    $display("FAIL req_timeout: addr %h never accepted, expected acceptance within 100 cycles", addr);
  endtask

  task automatic expect_read(input int acc_cyc, input logic [31:0] exp_data, input string name);
    while (cyc < acc_cyc + LATENCY) idle(1);
    check_bit({name, "_valid"}, o_mem_valid, 1'b1);
    check({name, "_data"}, o_mem_rdata, exp_data);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb_q.size() > 0 && t < 50) begin
      idle(1);
      t++;
    end
    check_int("drain", sb_q.size(), 0);
    idle(1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, a0, a1, a2, r1, r2, seen;
    i_rst       = 1'b1;
    i_mem_ren   = 1'b0;
    i_mem_wen   = 1'b0;
    i_mem_addr  = 32'h0;
    i_mem_wdata = 32'h0;
    repeat (3) @(negedge i_clk);
    check_bit("reset_ready", o_mem_ready, 1'b0);
    check_bit("reset_valid", o_mem_valid, 1'b0);
    check("reset_rdata", o_mem_rdata, 32'h0);
    i_rst = 1'b0;
    @(negedge i_clk);
    check_bit("ready_after_reset", o_mem_ready, 1'b1);

    for (int i = 0; i < DEPTH; i++) req(1'b0, 1'b1, 32'(i * 4), $urandom, c);

    // Write then read the next cycle.
    req(1'b0, 1'b1, 32'h40, 32'hDEADBEEF, c);
    req(1'b1, 1'b0, 32'h40, 32'h0, r1);
    while (cyc < r1 + LATENCY - 1) idle(1);
    check_bit("wr_rd_not_early", o_mem_valid, 1'b0);
    expect_read(r1, 32'hDEADBEEF, "wr_rd");
    drain();

    // Backpressure with reads held high back to back.
    req(1'b1, 1'b0, 32'h0, 32'h0, a0);
    req(1'b1, 1'b0, 32'h4, 32'h0, a1);
    @(negedge i_clk);
    check_bit("full_not_ready", o_mem_ready, 1'b0);
    req(1'b1, 1'b0, 32'h8, 32'h0, a2);
`ifndef MEM_RESPONDER_RANDOM_STALL_EN
    check_int("bp_second_accept", a1, a0 + 1);
    check_int("bp_third_accept", a2, a0 + LATENCY + 1);
`endif
    drain();

    // Upper address bits alias onto the same word.
    req(1'b0, 1'b1, 32'h1000_0010, 32'h12345678, c);
    req(1'b1, 1'b0, 32'h0000_0010, 32'h0, r1);
    expect_read(r1, 32'h12345678, "alias");
    drain();

    // A read returns the value present when it was accepted.
    req(1'b0, 1'b1, 32'h20, 32'h1, c);
    req(1'b1, 1'b0, 32'h20, 32'h0, r1);
    req(1'b0, 1'b1, 32'h20, 32'h2, c);
    expect_read(r1, 32'h1, "hazard_old");
    req(1'b1, 1'b0, 32'h20, 32'h0, r2);
    expect_read(r2, 32'h2, "hazard_new");
    drain();

    // Reset with two reads in flight.
    req(1'b0, 1'b1, 32'h80, 32'hCAFEF00D, c);
    req(1'b1, 1'b0, 32'h80, 32'h0, c);
    req(1'b1, 1'b0, 32'h84, 32'h0, c);
    @(negedge i_clk);
    i_rst     = 1'b1;
    i_mem_ren = 1'b0;
    i_mem_wen = 1'b0;
    sb_q.delete();
    @(negedge i_clk);
    i_rst = 1'b0;
    seen = 0;
    for (int k = 0; k < LATENCY + 2; k++) begin
      idle(1);
      if (o_mem_valid) seen++;
    end
    check_int("rst_no_valid", seen, 0);
`ifndef MEM_RESPONDER_RANDOM_STALL_EN
    check_bit("rst_ready_release", o_mem_ready, 1'b1);
`endif
    req(1'b1, 1'b0, 32'h80, 32'h0, r1);
    expect_read(r1, 32'hCAFEF00D, "rst_mem_kept");
    drain();

    // Randomized cache-like traffic, including occasional illegal ren+wen.
    for (int n = 0; n < 200; n++) begin
      int          op;
      logic [31:0] ra;
      logic [31:0] rd;
      op = $urandom_range(0, 9);
      ra = $urandom;
      rd = $urandom;
      if ($urandom_range(0, 3) == 0) idle(1);
      if (op < 5)      req(1'b1, 1'b0, ra, 32'h0, c);
      else if (op < 9) req(1'b0, 1'b1, ra, rd, c);
      else             req(1'b1, 1'b1, ra, rd, c);
    end
    drain();

`ifdef MEM_RESPONDER_RANDOM_STALL_EN
    tests++;
    if (rdy_obs == 0 || rdy_low * 100 < 15 * rdy_obs || rdy_low * 100 > 35 * rdy_obs) begin
      fails++;
      $display("FAIL stall_fraction: got %0d of %0d cycles low, expected 15-35 percent",
               rdy_low, rdy_obs);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
